// File: rtl/single_proc_pkg.sv
// Shared constants, ALU-op enum, encoders and boot ROM image for the single-cycle RV32I-subset core.
package single_proc_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_W       = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR
  } alu_op_e;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OP_R};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, F3_W, imm[4:0], OP_STORE};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
  endfunction

  // Fixed boot program; everything past word 10 is a NOP.
  function automatic logic [31:0] rom_word(input logic [31:0] idx);
    logic [31:0] w;
    w = NOP_INSTR;
    case (idx)
      32'd0:   w = enc_i(12'd5, 5'd0, F3_ADD_SUB, 5'd1, OP_IMM);
      32'd1:   w = enc_i(12'd3, 5'd0, F3_ADD_SUB, 5'd2, OP_IMM);
      32'd2:   w = enc_r(F7_BASE, 5'd2, 5'd1, F3_ADD_SUB, 5'd3);
      32'd3:   w = enc_r(F7_SUB, 5'd2, 5'd1, F3_ADD_SUB, 5'd4);
      32'd4:   w = enc_r(F7_BASE, 5'd2, 5'd1, F3_AND, 5'd5);
      32'd5:   w = enc_r(F7_BASE, 5'd2, 5'd1, F3_OR, 5'd6);
      32'd6:   w = enc_s(12'd0, 5'd3, 5'd0);
      32'd7:   w = enc_i(12'd0, 5'd0, F3_W, 5'd7, OP_LOAD);
      32'd8:   w = enc_b(13'd8, 5'd3, 5'd7);
      32'd9:   w = enc_i(12'd1, 5'd0, F3_ADD_SUB, 5'd8, OP_IMM);
      32'd10:  w = enc_b(13'd0, 5'd0, 5'd0);
      default: w = NOP_INSTR;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports, one write port, x0 hardwired to zero.
module reg_file
  import single_proc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  input  logic        i_we,
  input  logic [4:0]  i_rd_addr,
  input  logic [31:0] i_rd_data
);

  logic [31:0] regs [0:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (i_we && (i_rd_addr != 5'd0)) begin
      regs[i_rd_addr] <= i_rd_data;
    end
  end

  assign o_rs1_data = (i_rs1_addr == 5'd0) ? '0 : regs[i_rs1_addr];
  assign o_rs2_data = (i_rs2_addr == 5'd0) ? '0 : regs[i_rs2_addr];

endmodule

// File: rtl/top_single_processor.sv
// Single-cycle RV32I-subset core (add/sub/and/or/addi/lw/sw/beq), one instruction per clock.
// Define SINGLE_PROC_TRACE_EN for a simulation-only per-cycle commit trace.
module top_single_processor
  import single_proc_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned DMEM_DEPTH = 64
) (
  input logic clk,
  input logic reset
);

  localparam int unsigned IAW = $clog2(IMEM_DEPTH);
  localparam int unsigned DAW = $clog2(DMEM_DEPTH);

  logic [31:0] pc;
  logic [31:0] dmem [0:DMEM_DEPTH-1];

  logic [IAW-1:0] w_imem_idx;
  logic [31:0]    w_instr;
  logic [6:0]     w_opcode;
  logic [2:0]     w_funct3;
  logic [6:0]     w_funct7;
  logic [4:0]     w_rd, w_rs1, w_rs2;
  logic [31:0]    w_imm_i, w_imm_s, w_imm_b;
  logic [31:0]    w_rs1_data, w_rs2_data;
  logic [31:0]    w_alu_b, w_alu_res, w_rd_data, w_pc_next;
  logic [DAW-1:0] w_mem_idx;
  logic           w_reg_we, w_mem_we, w_branch, w_use_imm, w_wb_mem, w_zero;
  logic [31:0]    w_imm_sel;
  alu_op_e        w_alu_op;
  logic           w_unused_bits;

  assign w_imem_idx = pc[IAW+1:2];
  assign w_instr    = rom_word(32'(w_imem_idx));

  assign w_opcode = w_instr[6:0];
  assign w_rd     = w_instr[11:7];
  assign w_funct3 = w_instr[14:12];
  assign w_rs1    = w_instr[19:15];
  assign w_rs2    = w_instr[24:20];
  assign w_funct7 = w_instr[31:25];

  assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                    w_instr[11:8], 1'b0};

  // Unrecognised opcode/funct combinations fall through with every enable low (NOP).
  always_comb begin
    w_reg_we  = 1'b0;
    w_mem_we  = 1'b0;
    w_branch  = 1'b0;
    w_use_imm = 1'b0;
    w_wb_mem  = 1'b0;
    w_imm_sel = w_imm_i;
    w_alu_op  = ALU_ADD;
    case (w_opcode)
      OP_R: begin
        if (w_funct3 == F3_ADD_SUB && w_funct7 == F7_BASE) begin
          w_reg_we = 1'b1;
          w_alu_op = ALU_ADD;
        end else if (w_funct3 == F3_ADD_SUB && w_funct7 == F7_SUB) begin
          w_reg_we = 1'b1;
          w_alu_op = ALU_SUB;
        end else if (w_funct3 == F3_AND && w_funct7 == F7_BASE) begin
          w_reg_we = 1'b1;
          w_alu_op = ALU_AND;
        end else if (w_funct3 == F3_OR && w_funct7 == F7_BASE) begin
          w_reg_we = 1'b1;
          w_alu_op = ALU_OR;
        end
      end
      OP_IMM: begin
        if (w_funct3 == F3_ADD_SUB) begin
          w_reg_we  = 1'b1;
          w_use_imm = 1'b1;
        end
      end
      OP_LOAD: begin
        if (w_funct3 == F3_W) begin
          w_reg_we  = 1'b1;
          w_use_imm = 1'b1;
          w_wb_mem  = 1'b1;
        end
      end
      OP_STORE: begin
        if (w_funct3 == F3_W) begin
          w_mem_we  = 1'b1;
          w_use_imm = 1'b1;
          w_imm_sel = w_imm_s;
        end
      end
      OP_BRANCH: begin
        if (w_funct3 == F3_BEQ) begin
          w_branch = 1'b1;
          w_alu_op = ALU_SUB;
        end
      end
      default: ;
    endcase
  end

  reg_file u_reg_file (
    .clk        (clk),
    .rst_n      (reset),
    .i_rs1_addr (w_rs1),
    .i_rs2_addr (w_rs2),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data),
    .i_we       (w_reg_we),
    .i_rd_addr  (w_rd),
    .i_rd_data  (w_rd_data)
  );

  assign w_alu_b = w_use_imm ? w_imm_sel : w_rs2_data;

  always_comb begin
    w_alu_res = '0;
    case (w_alu_op)
      ALU_ADD: w_alu_res = w_rs1_data + w_alu_b;
      ALU_SUB: w_alu_res = w_rs1_data - w_alu_b;
      ALU_AND: w_alu_res = w_rs1_data & w_alu_b;
      ALU_OR:  w_alu_res = w_rs1_data | w_alu_b;
      default: w_alu_res = '0;
    endcase
  end

  assign w_zero    = (w_alu_res == 32'd0);
  assign w_mem_idx = w_alu_res[DAW+1:2];
  assign w_rd_data = w_wb_mem ? dmem[w_mem_idx] : w_alu_res;
  assign w_pc_next = (w_branch && w_zero) ? (pc + w_imm_b) : (pc + 32'd4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= '0;
    end else begin
      pc <= w_pc_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DMEM_DEPTH); i++) dmem[i] <= '0;
    end else if (w_mem_we) begin
      dmem[w_mem_idx] <= w_rs2_data;
    end
  end

  // Address bits outside the ROM/RAM index are deliberately ignored (aliasing).
  assign w_unused_bits = ^{pc[1:0], pc[31:IAW+2], w_alu_res[1:0], w_alu_res[31:DAW+2]};

`ifdef SINGLE_PROC_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      if (w_reg_we && (w_rd != 5'd0)) begin
        $display("trace pc=%08h instr=%08h rd=x%0d val=%08h", pc, w_instr, w_rd, w_rd_data);
      end else if (w_mem_we) begin
        $display("trace pc=%08h instr=%08h st_addr=%08h val=%08h", pc, w_instr, w_alu_res,
                 w_rs2_data);
      end else begin
        $display("trace pc=%08h instr=%08h", pc, w_instr);
      end
    end
  end
`endif

endmodule

// File: tb/tb_top_single_processor.sv
// Bench for top_single_processor: boot program, async reset, x0 handling, random instruction stream.
module tb_top_single_processor;

  localparam int DD = 64;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] f_instr;

  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [DD];
  logic [31:0] m_pc;

  top_single_processor #(
    .IMEM_DEPTH (64),
    .DMEM_DEPTH (DD)
  ) dut (
    .clk   (clk),
    .reset (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] e_i(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] e_s(input logic [11:0] imm, input logic [4:0] rs2,
                                      input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] e_b(input logic [12:0] imm, input logic [4:0] rs2,
                                      input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++;
    if (dut.pc !== 32'd0) begin
      failures++;
      $display("FAIL reset_pc got=%08h want=00000000", dut.pc);
    end
    checks++;
    if (dut.u_reg_file.regs[1] !== 32'd0 || dut.dmem[0] !== 32'd0) begin
      failures++;
      $display("FAIL reset_state x1=%08h dmem0=%08h want=0", dut.u_reg_file.regs[1], dut.dmem[0]);
    end
    #4;
    reset = 1'b1;
    tick();
    checks++;
    if (dut.pc !== 32'd4 || dut.u_reg_file.regs[1] !== 32'd5) begin
      failures++;
      $display("FAIL first_edge pc=%08h x1=%08h want pc=4 x1=5", dut.pc, dut.u_reg_file.regs[1]);
    end
  endtask

  task automatic test_program();
    logic [31:0] exp_r [8];
    exp_r = '{32'd0, 32'd5, 32'd3, 32'd8, 32'd2, 32'd1, 32'd7, 32'd8};
    repeat (7) tick();
    checks++;
    if (dut.pc !== 32'd32) begin
      failures++;
      $display("FAIL prog_pc got=%08h want=00000020", dut.pc);
    end
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (dut.u_reg_file.regs[i] !== exp_r[i]) begin
        failures++;
        $display("FAIL prog_x%0d got=%08h want=%08h", i, dut.u_reg_file.regs[i], exp_r[i]);
      end
    end
    checks++;
    if (dut.dmem[0] !== 32'd8) begin
      failures++;
      $display("FAIL prog_dmem0 got=%08h want=00000008", dut.dmem[0]);
    end
  endtask

  task automatic test_halt_loop();
    repeat (2) tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (dut.pc !== 32'd40 || dut.u_reg_file.regs[8] !== 32'd0 || dut.dmem[0] !== 32'd8) begin
        failures++;
        $display("FAIL halt_c%0d pc=%08h x8=%08h dmem0=%08h want pc=28 x8=0 dmem0=8", c, dut.pc,
                 dut.u_reg_file.regs[8], dut.dmem[0]);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    int nz;
    reset = 1'b0;
    #1;
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.u_reg_file.regs[i] !== 32'd0) nz++;
    for (int i = 0; i < DD; i++) if (dut.dmem[i] !== 32'd0) nz++;
    checks++;
    if (dut.pc !== 32'd0 || nz != 0) begin
      failures++;
      $display("FAIL async_clear pc=%08h nonzero_words=%0d want pc=0 nonzero=0", dut.pc, nz);
    end
    #1;
    reset = 1'b1;
    repeat (5) tick();
    checks++;
    if (dut.pc !== 32'd20) begin
      failures++;
      $display("FAIL async_cycle5_pc got=%08h want=00000014", dut.pc);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (dut.pc !== 32'd0 || dut.u_reg_file.regs[1] !== 32'd0 || dut.u_reg_file.regs[3] !== 32'd0) begin
      failures++;
      $display("FAIL async_mid pc=%08h x1=%08h x3=%08h want all 0", dut.pc,
               dut.u_reg_file.regs[1], dut.u_reg_file.regs[3]);
    end
    #1;
    reset = 1'b1;
    repeat (10) tick();
    checks++;
    if (dut.pc !== 32'd40 || dut.u_reg_file.regs[3] !== 32'd8 || dut.u_reg_file.regs[7] !== 32'd8 ||
        dut.dmem[0] !== 32'd8 || dut.u_reg_file.regs[8] !== 32'd0) begin
      failures++;
      $display("FAIL rerun pc=%08h x3=%08h x7=%08h dmem0=%08h x8=%08h want 28/8/8/8/0", dut.pc,
               dut.u_reg_file.regs[3], dut.u_reg_file.regs[7], dut.dmem[0],
               dut.u_reg_file.regs[8]);
    end
  endtask

  task automatic test_x0_override();
    pulse_reset();
    f_instr = e_i(12'd77, 5'd0, 3'b000, 5'd9, 7'h13);
    force dut.w_instr = f_instr;
    tick();
    f_instr = e_i(12'd123, 5'd0, 3'b000, 5'd0, 7'h13);
    force dut.w_instr = f_instr;
    tick();
    checks++;
    if (dut.u_reg_file.regs[0] !== 32'd0) begin
      failures++;
      $display("FAIL x0_addi got=%08h want=00000000", dut.u_reg_file.regs[0]);
    end
    f_instr = e_r(7'h00, 3'b000, 5'd11, 5'd0, 5'd9);
    force dut.w_instr = f_instr;
    tick();
    checks++;
    if (dut.u_reg_file.regs[11] !== 32'd77) begin
      failures++;
      $display("FAIL x0_read got x11=%08h want=0000004d", dut.u_reg_file.regs[11]);
    end
    f_instr = e_r(7'h00, 3'b000, 5'd0, 5'd9, 5'd9);
    force dut.w_instr = f_instr;
    tick();
    checks++;
    if (dut.u_reg_file.regs[0] !== 32'd0 || dut.pc !== 32'd16) begin
      failures++;
      $display("FAIL x0_add x0=%08h pc=%08h want x0=0 pc=10", dut.u_reg_file.regs[0], dut.pc);
    end
    release dut.w_instr;
  endtask

  task automatic test_random();
    pulse_reset();
    m_pc = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    for (int i = 0; i < DD; i++) m_dmem[i] = '0;
    for (int it = 0; it < 400; it++) begin
      int          k;
      int          idx;
      logic [4:0]  rd, rs1, rs2;
      logic [11:0] imm;
      logic [12:0] immb;
      logic [31:0] ins, a, b, s, res, addr, npc;
      bit          wr, st;
      k    = $urandom_range(0, 11);
      rd   = 5'($urandom_range(0, 9));
      rs1  = 5'($urandom_range(0, 9));
      rs2  = 5'($urandom_range(0, 9));
      imm  = 12'($urandom);
      immb = {12'($urandom), 1'b0};
      if (k == 8) rs2 = rs1;
      a    = m_regs[rs1];
      b    = m_regs[rs2];
      s    = 32'(signed'(imm));
      wr   = 1'b0;
      st   = 1'b0;
      res  = '0;
      idx  = 0;
      npc  = m_pc + 32'd4;
      case (k)
        0: begin ins = e_r(7'h00, 3'b000, rd, rs1, rs2); res = a + b; wr = 1'b1; end
        1: begin ins = e_r(7'h20, 3'b000, rd, rs1, rs2); res = a - b; wr = 1'b1; end
        2: begin ins = e_r(7'h00, 3'b111, rd, rs1, rs2); res = a & b; wr = 1'b1; end
        3: begin ins = e_r(7'h00, 3'b110, rd, rs1, rs2); res = a | b; wr = 1'b1; end
        4: begin ins = e_i(imm, rs1, 3'b000, rd, 7'h13); res = a + s; wr = 1'b1; end
        5: begin
          ins  = e_i(imm, rs1, 3'b010, rd, 7'h03);
          addr = a + s;
          idx  = int'((addr / 4) % DD);
          res  = m_dmem[idx];
          wr   = 1'b1;
        end
        6: begin
          ins  = e_s(imm, rs2, rs1);
          addr = a + s;
          idx  = int'((addr / 4) % DD);
          m_dmem[idx] = b;
          st   = 1'b1;
        end
        7, 8: begin
          ins = e_b(immb, rs2, rs1);
          if (a == b) npc = m_pc + 32'(signed'(immb));
        end
        9:       ins = {25'($urandom), 7'b1110011};
        10:      ins = e_r(7'h01, 3'b000, rd, rs1, rs2);
        default: ins = e_i(imm, rs1, 3'b001, rd, 7'h13);
      endcase
      if (wr && rd != 5'd0) m_regs[rd] = res;
      m_pc = npc;
      f_instr = ins;
      force dut.w_instr = f_instr;
      tick();
      checks++;
      if (dut.pc !== m_pc || dut.u_reg_file.regs[rd] !== m_regs[rd]) begin
        failures++;
        $display("FAIL rand_it%0d kind=%0d instr=%08h pc=%08h x%0d=%08h want pc=%08h val=%08h", it,
                 k, ins, dut.pc, rd, dut.u_reg_file.regs[rd], m_pc, m_regs[rd]);
      end
      if (st) begin
        checks++;
        if (dut.dmem[idx] !== m_dmem[idx]) begin
          failures++;
          $display("FAIL rand_store_it%0d dmem[%0d]=%08h want=%08h", it, idx, dut.dmem[idx],
                   m_dmem[idx]);
        end
      end
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.u_reg_file.regs[i] !== m_regs[i]) begin
        failures++;
        $display("FAIL rand_final_x%0d got=%08h want=%08h", i, dut.u_reg_file.regs[i], m_regs[i]);
      end
    end
    for (int i = 0; i < DD; i++) begin
      checks++;
      if (dut.dmem[i] !== m_dmem[i]) begin
        failures++;
        $display("FAIL rand_final_dmem%0d got=%08h want=%08h", i, dut.dmem[i], m_dmem[i]);
      end
    end
    release dut.w_instr;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    f_instr  = '0;
    test_reset();
    test_program();
    test_halt_loop();
    test_async_reset();
    test_x0_override();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
